// File: rtl/send_ack_rr_arbiter.sv
// Round-robin arbiter sharing one Send/Ack (active-low, four-phase) stage between N_REQ requesters.
// Optional REQ-phase abort on a stalled Ack_in is enabled by defining ARB_TIMEOUT_EN.
module send_ack_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       CP,
  input  logic                       MR_n,
  input  logic [N_REQ-1:0]           Send_in,
  input  logic [N_REQ-1:0]           Ga,
  input  logic [N_REQ*DW-1:0]        Data_in,
  output logic [N_REQ-1:0]           Ack_out,
  output logic                       Send_out,
  output logic [DW-1:0]              Data_out,
  input  logic                       Ack_in,
  output logic [$clog2(N_REQ)-1:0]   Grant_id,
  output logic                       Busy,
  output logic                       Err,
  output logic [1:0]                 dbg_state
);

  localparam int GW = $clog2(N_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [1:0] REL  = 2'd3;

  // Handshake: a side requests by driving Send low; the partner answers by driving Ack low;
  // Send then returns high and Ack follows it high. Every phase change is taken on a CP edge.

  logic [1:0]       state_q, state_d;
  logic             send_q, send_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [DW-1:0]    data_q, data_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
`endif

  logic [N_REQ-1:0] elig;
  logic             sel_found;
  logic [GW-1:0]    sel_idx;
  logic [GW-1:0]    scan_idx;

  assign elig = ~Send_in & Ga;

  // Scan starts one past the last grant so the previous winner is considered last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = GW'((int'(ptr_q) + k) % N_REQ);
      if (!sel_found && elig[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    ack_d   = ack_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          send_d  = 1'b0;
          data_d  = Data_in[sel_idx*DW +: DW];
          grant_d = sel_idx;
          ptr_d   = sel_idx;
          state_d = REQ;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (!Ack_in) begin
          ack_d[grant_q] = 1'b0;
          state_d        = ACK;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abort: requester is never acked and stays pending for a later round.
          send_d  = 1'b1;
          err_d   = 1'b1;
          state_d = REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACK: begin
        if (Send_in[grant_q]) begin
          send_d  = 1'b1;
          state_d = REL;
        end
      end
      default: begin
        if (Ack_in) begin
          ack_d   = '1;
          state_d = IDLE;
        end
      end
    endcase
`ifndef ARB_TIMEOUT_EN
    err_d = 1'b0;
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      state_q <= IDLE;
      send_q  <= 1'b1;
      ack_q   <= '1;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= GW'(N_REQ - 1);
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign Ack_out   = ack_q;
  assign Send_out  = send_q;
  assign Data_out  = data_q;
  assign Grant_id  = grant_q;
  assign Busy      = busy_q;
  assign Err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_send_ack_rr_arbiter.sv
// Directed bench for send_ack_rr_arbiter (N_REQ=4, DW=16, TIMEOUT=8).
module tb_send_ack_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 16;

  logic                  CP;
  logic                  MR_n;
  logic [N_REQ-1:0]      Send_in;
  logic [N_REQ-1:0]      Ga;
  logic [N_REQ*DW-1:0]   Data_in;
  logic [N_REQ-1:0]      Ack_out;
  logic                  Send_out;
  logic [DW-1:0]         Data_out;
  logic                  Ack_in;
  logic [1:0]            Grant_id;
  logic                  Busy;
  logic                  Err;
  logic [1:0]            dbg_state;

  int total;
  int bad;

  logic [DW-1:0] dat_tbl [N_REQ];

  send_ack_rr_arbiter #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(8)) dut (
    .CP(CP), .MR_n(MR_n), .Send_in(Send_in), .Ga(Ga), .Data_in(Data_in),
    .Ack_out(Ack_out), .Send_out(Send_out), .Data_out(Data_out), .Ack_in(Ack_in),
    .Grant_id(Grant_id), .Busy(Busy), .Err(Err), .dbg_state(dbg_state)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full four-phase transfer for requester g, then g requests again.
  task automatic hs(input int g);
    logic [N_REQ-1:0] e;
    e    = '1;
    e[g] = 1'b0;
    tick();
    chk("grant_send", 32'(Send_out), 32'd0);
    chk("grant_id", 32'(Grant_id), 32'(g));
    chk("grant_data", 32'(Data_out), 32'(dat_tbl[g]));
    chk("grant_state", 32'(dbg_state), 32'd1);
    Ack_in = 1'b0;
    tick();
    chk("ack_low", 32'(Ack_out), 32'(e));
    Send_in[g] = 1'b1;
    tick();
    chk("send_rise", 32'(Send_out), 32'd1);
    Ack_in = 1'b1;
    tick();
    chk("ack_rise", 32'(Ack_out), 32'hF);
    chk("idle_busy", 32'(Busy), 32'd0);
    Send_in[g] = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    dat_tbl[0] = 16'h1111;
    dat_tbl[1] = 16'hA5A5;
    dat_tbl[2] = 16'h3333;
    dat_tbl[3] = 16'h4444;
    Data_in = {dat_tbl[3], dat_tbl[2], dat_tbl[1], dat_tbl[0]};
    MR_n    = 1'b0;
    Send_in = 4'hF;
    Ga      = 4'hF;
    Ack_in  = 1'b1;
    tick();
    chk("rst_send", 32'(Send_out), 32'd1);
    chk("rst_ack", 32'(Ack_out), 32'hF);
    chk("rst_data", 32'(Data_out), 32'd0);
    chk("rst_gid", 32'(Grant_id), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    MR_n = 1'b1;
    tick();

    // Single requester 1
    Send_in = 4'b1101;
    tick();
    chk("single_send", 32'(Send_out), 32'd0);
    chk("single_data", 32'(Data_out), 32'hA5A5);
    chk("single_gid", 32'(Grant_id), 32'd1);
    chk("single_busy", 32'(Busy), 32'd1);
    Ack_in = 1'b0;
    tick();
    chk("single_ack", 32'(Ack_out), 32'b1101);
    Send_in = 4'hF;
    tick();
    chk("single_rel_send", 32'(Send_out), 32'd1);
    chk("single_rel_ack", 32'(Ack_out), 32'b1101);
    Ack_in = 1'b1;
    tick();
    chk("single_idle_ack", 32'(Ack_out), 32'hF);
    chk("single_idle_busy", 32'(Busy), 32'd0);

    // Reset in the middle of REQ
    Send_in = 4'b1011;
    tick();
    chk("pre_rst_send", 32'(Send_out), 32'd0);
    chk("pre_rst_gid", 32'(Grant_id), 32'd2);
    MR_n = 1'b0;
    #2;
    chk("midrst_send", 32'(Send_out), 32'd1);
    chk("midrst_ack", 32'(Ack_out), 32'hF);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_gid", 32'(Grant_id), 32'd0);
    chk("midrst_data", 32'(Data_out), 32'd0);
    Send_in = 4'hF;
    tick();
    MR_n = 1'b1;
    tick();

    // Round-robin with all four requesting
    Send_in = 4'h0;
    hs(0); hs(1); hs(2); hs(3); hs(0);

    // Gated eligibility, then requester 1 ungated
    Ga = 4'b0101;
    hs(2); hs(0); hs(2);
    Ga = 4'b0111;
    hs(0); hs(1); hs(2);

    // Only requester 3 pending: granted, then wraps back to itself
    Ga      = 4'hF;
    Send_in = 4'b0111;
    hs(3); hs(3);
    Send_in = 4'hF;

    // Ack_in low while idle changes nothing and blocks no grant
    Ack_in = 1'b0;
    tick();
    chk("idleack_send", 32'(Send_out), 32'd1);
    chk("idleack_ack", 32'(Ack_out), 32'hF);
    chk("idleack_busy", 32'(Busy), 32'd0);
    chk("idleack_gid", 32'(Grant_id), 32'd3);
    chk("idleack_data", 32'(Data_out), 32'h4444);
    Send_in = 4'b1110;
    tick();
    chk("idleack_grant_send", 32'(Send_out), 32'd0);
    chk("idleack_grant_gid", 32'(Grant_id), 32'd0);
    tick();
    chk("idleack_grant_ack", 32'(Ack_out), 32'b1110);
    Send_in = 4'hF;
    tick();
    chk("idleack_rel_send", 32'(Send_out), 32'd1);
    Ack_in = 1'b1;
    tick();
    chk("idleack_done_ack", 32'(Ack_out), 32'hF);

`ifdef ARB_TIMEOUT_EN
    // Stalled stage: abort after 8 cycles, then the other pending requester
    Send_in = 4'b1001;
    tick();
    chk("to_send_fall", 32'(Send_out), 32'd0);
    chk("to_gid", 32'(Grant_id), 32'd1);
    repeat (7) tick();
    chk("to_send_hold", 32'(Send_out), 32'd0);
    chk("to_err_pre", 32'(Err), 32'd0);
    tick();
    chk("to_send_rise", 32'(Send_out), 32'd1);
    chk("to_err", 32'(Err), 32'd1);
    chk("to_ack", 32'(Ack_out), 32'hF);
    tick();
    chk("to_idle_busy", 32'(Busy), 32'd0);
    tick();
    chk("to_next_gid", 32'(Grant_id), 32'd2);
    chk("to_next_send", 32'(Send_out), 32'd0);
    chk("to_err_sticky", 32'(Err), 32'd1);
    Ack_in = 1'b0;
    tick();
    chk("to_next_ack", 32'(Ack_out), 32'b1011);
    Send_in = 4'hF;
    tick();
    Ack_in = 1'b1;
    tick();
    chk("to_done_ack", 32'(Ack_out), 32'hF);
`else
    chk("err_tied", 32'(Err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
